// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RISC-V M-extension multiply/divide unit (shift-add / restoring divide)
module muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] srcA_i,
    input  logic [DATA_WIDTH-1:0] srcB_i,
    input  logic                  kill_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  zero_o
);
    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [2:0]           op_q;
    logic [W-1:0]         b_q;
    logic [W:0]           hi_q;
    logic [W-1:0]         lo_q;
    logic                 neg_q;
    logic                 ready_q;
    logic                 valid_q;
    logic [W-1:0]         result_q;

    logic         a_sgn, b_sgn, neg_a, neg_b, neg_d, div_zero, ovf;
    logic [W-1:0] mag_a, mag_b, sp_res;
    logic [W:0]   mul_sum, shifted, diff, hi_d;
    logic [W-1:0] lo_d, q_s, r_s, fix_res;
    logic [2*W-1:0] prod_s;

    // Request decode: operand magnitudes, result sign and the short-cut cases
    always_comb begin
        a_sgn    = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
        b_sgn    = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
        neg_a    = a_sgn && srcA_i[W-1];
        neg_b    = b_sgn && srcB_i[W-1];
        mag_a    = neg_a ? -srcA_i : srcA_i;
        mag_b    = neg_b ? -srcB_i : srcB_i;
        neg_d    = (op_i[2] && op_i[1]) ? neg_a : (neg_a ^ neg_b);
        div_zero = op_i[2] && (srcB_i == '0);
        ovf      = op_i[2] && !op_i[0] && (srcA_i == {1'b1, {(W-1){1'b0}}}) && (srcB_i == '1);
        sp_res   = div_zero ? (op_i[1] ? srcA_i : '1) : (op_i[1] ? '0 : srcA_i);
    end

    // One iteration step (multiply: shift-add, divide: restoring subtract) and final sign fix-up
    always_comb begin
        mul_sum = hi_q + {1'b0, (lo_q[0] ? b_q : {W{1'b0}})};
        shifted = {hi_q[W-1:0], lo_q[W-1]};
        diff    = shifted - {1'b0, b_q};
        hi_d    = op_q[2] ? (diff[W] ? shifted : diff) : {1'b0, mul_sum[W:1]};
        lo_d    = op_q[2] ? {lo_q[W-2:0], ~diff[W]} : {mul_sum[0], lo_q[W-1:1]};
        prod_s  = neg_q ? -{hi_q[W-1:0], lo_q} : {hi_q[W-1:0], lo_q};
        q_s     = neg_q ? -lo_q : lo_q;
        r_s     = neg_q ? -hi_q[W-1:0] : hi_q[W-1:0];
        fix_res = op_q[2] ? (op_q[1] ? r_s : q_s)
                          : ((op_q[1:0] == 2'b00) ? prod_s[W-1:0] : prod_s[2*W-1:W]);
    end

    // Control FSM with registered handshake outputs; reset beats kill, kill beats everything else
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_q    <= 1'b0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else if (kill_i) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (valid_i) begin
                    op_q    <= op_i;
                    ready_q <= 1'b0;
                    if (div_zero || ovf) begin
                        state_q  <= DONE;
                        result_q <= sp_res;
                        valid_q  <= 1'b1;
                    end else begin
                        state_q <= CALC;
                        cnt_q   <= CNT_WIDTH'(W);
                        b_q     <= op_i[2] ? mag_b : mag_a;
                        lo_q    <= op_i[2] ? mag_a : mag_b;
                        hi_q    <= '0;
                        neg_q   <= neg_d;
                    end
                end
                CALC: if (cnt_q == '0) begin
                    state_q <= FIX;
                end else begin
                    cnt_q <= cnt_q - CNT_WIDTH'(1);
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                end
                FIX: begin
                    result_q <= fix_res;
                    valid_q  <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: if (ready_i) begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o  = ready_q;
    assign valid_o  = valid_q;
    assign result_o = result_q;
    assign zero_o   = (result_q == '0);
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector bench for muldiv_unit at DATA_WIDTH=32
module tb_muldiv_unit;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [2:0]  op_i = '0;
    logic [31:0] srcA_i = '0;
    logic [31:0] srcB_i = '0;
    logic        kill_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] result_o;
    logic        zero_o;

    int total = 0;
    int bad = 0;

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .op_i(op_i), .srcA_i(srcA_i), .srcB_i(srcB_i), .kill_i(kill_i),
        .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .zero_o(zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // lat = edges after the accepting edge until valid_o is seen (0: already high right after it)
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
        int n;
        chk({tag, ".rdy"}, 64'(ready_o), 64'd1);
        valid_i = 1'b1;
        op_i    = op;
        srcA_i  = a;
        srcB_i  = b;
        tick();
        valid_i = 1'b0;
        op_i    = 3'($urandom);
        srcA_i  = $urandom;
        srcB_i  = $urandom;
        n = 0;
        while (!valid_o && n < 200) begin
            tick();
            n++;
        end
        chk({tag, ".lat"}, 64'(n), 64'(lat));
        chk({tag, ".res"}, 64'(result_o), 64'(exp));
        chk({tag, ".zero"}, 64'(zero_o), 64'(exp == 32'd0));
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        chk({tag, ".idle"}, 64'(ready_o), 64'd1);
    endtask

    initial begin
        int n;
        tick();
        tick();
        chk("rst.ready", 64'(ready_o), 64'd1);
        chk("rst.valid", 64'(valid_o), 64'd0);
        chk("rst.result", 64'(result_o), 64'd0);
        chk("rst.zero", 64'(zero_o), 64'd1);
        rst_ni = 1'b1;
        tick();

        do_op("mul",     3'b000, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 34);
        do_op("mulhu",   3'b011, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 34);
        do_op("mulh",    3'b001, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 34);
        do_op("mulhsu",  3'b010, 32'h00000002, 32'hFFFFFFFF, 32'h00000001, 34);
        do_op("mulhsu2", 3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 34);
        do_op("div",     3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34);
        do_op("rem",     3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34);
        do_op("divu",    3'b101, 32'h00000007, 32'h00000002, 32'h00000003, 34);
        do_op("remu",    3'b111, 32'h00000007, 32'h00000002, 32'h00000001, 34);
        do_op("div_nb",  3'b100, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 34);
        do_op("rem_nb",  3'b110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 34);
        do_op("remu_big",3'b111, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 34);
        do_op("divu_z",  3'b101, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 0);
        do_op("remu_z",  3'b111, 32'h00000005, 32'h00000000, 32'h00000005, 0);
        do_op("div_z",   3'b100, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 0);
        do_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
        do_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0);

        // backpressure: DIVU 100/7 = 14 held while the consumer stalls
        valid_i = 1'b1;
        op_i    = 3'b101;
        srcA_i  = 32'd100;
        srcB_i  = 32'd7;
        tick();
        valid_i = 1'b0;
        n = 0;
        while (!valid_o && n < 200) begin
            tick();
            n++;
        end
        chk("bp.res", 64'(result_o), 64'd14);
        for (int i = 0; i < 5; i++) begin
            valid_i = 1'b1;
            op_i    = 3'b000;
            srcA_i  = 32'd9;
            srcB_i  = 32'd9;
            tick();
            chk("bp.valid", 64'(valid_o), 64'd1);
            chk("bp.hold", 64'(result_o), 64'd14);
            chk("bp.ready", 64'(ready_o), 64'd0);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        chk("bp.idle", 64'(ready_o), 64'd1);
        chk("bp.vdrop", 64'(valid_o), 64'd0);

        // kill in DONE wins over a simultaneous new request
        do_op("pre_kill", 3'b000, 32'd6, 32'd7, 32'd42, 34);
        valid_i = 1'b1;
        op_i    = 3'b101;
        srcA_i  = 32'd9;
        srcB_i  = 32'd0;
        tick();
        kill_i = 1'b1;
        chk("kd.valid_pre", 64'(valid_o), 64'd1);
        tick();
        kill_i  = 1'b0;
        valid_i = 1'b0;
        chk("kd.ready", 64'(ready_o), 64'd1);
        chk("kd.valid", 64'(valid_o), 64'd0);
        chk("kd.held", 64'(result_o), 64'hFFFFFFFF);

        // kill alone mid-CALC discards the operation
        valid_i = 1'b1;
        op_i    = 3'b000;
        srcA_i  = 32'd5;
        srcB_i  = 32'd5;
        tick();
        valid_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        kill_i = 1'b1;
        tick();
        kill_i = 1'b0;
        chk("kc.ready", 64'(ready_o), 64'd1);
        for (int i = 0; i < 40; i++) tick();
        chk("kc.novalid", 64'(valid_o), 64'd0);
        chk("kc.result", 64'(result_o), 64'hFFFFFFFF);

        // kill and reset together at CALC cycle 10
        valid_i = 1'b1;
        op_i    = 3'b000;
        srcA_i  = 32'hFFFFFFFF;
        srcB_i  = 32'hFFFFFFFF;
        tick();
        valid_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        kill_i = 1'b1;
        rst_ni = 1'b0;
        tick();
        kill_i = 1'b0;
        rst_ni = 1'b1;
        chk("kr.valid", 64'(valid_o), 64'd0);
        chk("kr.ready", 64'(ready_o), 64'd1);
        chk("kr.result", 64'(result_o), 64'd0);
        chk("kr.zero", 64'(zero_o), 64'd1);
        do_op("mul3x4", 3'b000, 32'd3, 32'd4, 32'd12, 34);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
